fetch_if_id: RTL and testbench
==============================

# fetch_if_id

Fetch stage plus IF/ID pipeline register for the five-stage WISC-SP20 pipeline. It owns the PC and issues the instruction-memory address. It latches the fetched instruction and PC+2 into IF/ID, and obeys the hazard detector's `stall_decode` and `flush_fetch` (redirect) controls. It also detects HALT and then freezes fetch, feeding decode with invalid NOPs until a redirect or reset.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0800, instruction word (opcode 00001) inserted into IF/ID on flush, halt or reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_decode`  in  1  hold PC and IF/ID contents this cycle.
- `flush_fetch`  in  1  squash the instruction being fetched; asserted exactly when `PC_source == 2'b10`.
- `PC_source`  in  2  2'b10 = redirect to `target_pc`; any other value = sequential.
- `target_pc`  in  16  redirect target from the resolving stage.
- `inst_addr`  out  16  instruction-memory address, equal to the PC register.
- `inst_data`  in  16  instruction word, combinational read of `inst_addr`.
- `IF_ID_ins`  out  16  registered instruction to decode.
- `IF_ID_inc_pc`  out  16  registered PC+2 of that instruction.
- `IF_ID_valid`  out  1  registered; 1 = real fetched instruction, 0 = bubble.
- `halted`  out  1  registered; 1 = fetch frozen after HALT.

## Operation
- State: `pc_q[15:0]`, IF/ID register (`ins`, `inc_pc`, `valid`), and `halted` flag. Fetch state is derived from these: FETCH when `halted=0`, HALTED when `halted=1`.
- `inc = pc_q + 2`, computed mod 2^16. 16'hFFFE wraps to 16'h0000 with no carry out.
- Redirect is `PC_source==2'b10 || flush_fetch`. Both inputs are treated as one event.
- Per-edge priority, highest first:
  1. `rst`: `pc_q=RESET_PC`, `ins=NOP_INSTR`, `inc_pc=0`, `valid=0`, `halted=0`.
  2. Redirect, regardless of `stall_decode` or `halted`: `pc_q=target_pc`, `ins=NOP_INSTR`, `inc_pc=0`, `valid=0`, `halted=0`. A speculatively fetched HALT is cancelled.
  3. `stall_decode=1`: `pc_q` and the whole IF/ID register hold; `halted` holds.
  4. `halted=1`: `pc_q` holds; `ins=NOP_INSTR`, `inc_pc=0`, `valid=0`.
  5. Normal: `ins=inst_data`, `inc_pc=inc`, `valid=1`, `pc_q=inc`.
     - If `inst_data[15:11]==5'b00000` (HALT): `halted` is set, HALT itself is latched with `valid=1`, and `pc_q` holds instead of advancing.
- `inst_addr` is always `pc_q`, including while stalled or halted, so memory sees a stable address.
- Only the cases above write state; no combinational path runs from inputs to registered outputs.

## Timing
- Reset values: `inst_addr=RESET_PC`, `IF_ID_ins=NOP_INSTR`, `IF_ID_inc_pc=0`, `IF_ID_valid=0`, `halted=0`. These apply asynchronously on `rst` rise.
- Latency: an instruction at address A appears on `IF_ID_ins` one edge after `inst_addr==A`, with `IF_ID_inc_pc=A+2`.
- Throughput: one instruction per cycle when unstalled.
- Redirect: `inst_addr=target_pc` one edge after the redirect cycle. The first valid target instruction reaches IF/ID two edges after the redirect cycle, so exactly one bubble is inserted.
- Stall for N cycles: `inst_addr` and IF/ID are unchanged for N edges. Fetch resumes on the edge after `stall_decode` deasserts.
- HALT at A: next edge gives `IF_ID_ins`=HALT, `valid=1`, `halted=1`, `inst_addr=A`. Every following unstalled edge gives bubbles.
- Stall while halted: IF/ID holds, so the HALT or a bubble stays visible.
- Reset mid-stall, mid-redirect or while halted: reset values take effect immediately. The first fetch is from `RESET_PC` on the first edge after `rst` falls.

## Test plan
- Reset, then run from `RESET_PC=0` with memory holding ADDI words at 0, 2, 4 → on edges 1-3, `IF_ID_inc_pc`=2, 4, 6 with `valid=1`, and `inst_addr` steps 2, 4, 6.
- Stall: assert `stall_decode` for 3 cycles while `inst_addr=16'h0004` → `inst_addr` stays 0004 and IF/ID holds the word from 0002 with `inc_pc=0004`. On release the next edge latches the word at 0004.
- Redirect: `PC_source=2'b10`, `flush_fetch=1`, `target_pc=16'h0040` → next edge `IF_ID_ins=16'h0800`, `valid=0`, `inst_addr=0040`. The following edge latches the word at 0040 with `inc_pc=0042`.
- Redirect and stall in the same cycle (`target_pc=16'h0100`) → redirect wins: `inst_addr=0100` and IF/ID gets a NOP with `valid=0`.
- HALT (16'h0000) at 16'h000A → IF/ID gets 0000 with `valid=1` and `halted=1`. Ten further cycles give `inst_addr=000A` and bubbles. A redirect to 16'h0020 then clears `halted` and fetches from 0020.
- Wrap: redirect to 16'hFFFE containing an ADDI → `IF_ID_inc_pc=16'h0000` and `inst_addr=16'h0000` on the following edge.

Source files
------------

// File: rtl/fetch_if_id_if.sv
// +------------------------------------------------------------------+
// | fetch_if_id_if : fetch-stage control, imem and IF/ID signals      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface fetch_if_id_if;
  logic        stall_decode;
  logic        flush_fetch;
  logic [1:0]  PC_source;
  logic [15:0] target_pc;
  logic [15:0] inst_addr;
  logic [15:0] inst_data;
  logic [15:0] IF_ID_ins;
  logic [15:0] IF_ID_inc_pc;
  logic        IF_ID_valid;
  logic        halted;

  // Hazard unit, instruction memory and decode side.
  modport master (
    output stall_decode, flush_fetch, PC_source, target_pc, inst_data,
    input  inst_addr, IF_ID_ins, IF_ID_inc_pc, IF_ID_valid, halted
  );

  // Fetch stage side.
  modport slave (
    input  stall_decode, flush_fetch, PC_source, target_pc, inst_data,
    output inst_addr, IF_ID_ins, IF_ID_inc_pc, IF_ID_valid, halted
  );
endinterface

`default_nettype wire

// File: rtl/fetch_if_id.sv
// +------------------------------------------------------------------+
// | fetch_if_id : PC, instruction fetch and IF/ID register with HALT  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_if_id #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fetch_if_id_if.slave    bus
);

  logic [15:0] pc_q;
  logic [15:0] ins_q;
  logic [15:0] inc_pc_q;
  logic        valid_q;
  logic        halted_q;

  logic [15:0] inc;
  logic        redirect;
  logic        is_halt;

  assign inc      = pc_q + 16'd2;
  assign redirect = (bus.PC_source == 2'b10) || bus.flush_fetch;
  assign is_halt  = (bus.inst_data[15:11] == 5'b00000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ins_q    <= NOP_INSTR;
      inc_pc_q <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (redirect) begin
      // A redirect also cancels a HALT fetched down the wrong path.
      pc_q     <= bus.target_pc;
      ins_q    <= NOP_INSTR;
      inc_pc_q <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (bus.stall_decode) begin
      pc_q     <= pc_q;
      ins_q    <= ins_q;
      inc_pc_q <= inc_pc_q;
      valid_q  <= valid_q;
      halted_q <= halted_q;
    end else if (halted_q) begin
      ins_q    <= NOP_INSTR;
      inc_pc_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      ins_q    <= bus.inst_data;
      inc_pc_q <= inc;
      valid_q  <= 1'b1;
      if (is_halt) begin
        halted_q <= 1'b1;
      end else begin
        pc_q     <= inc;
      end
    end
  end

  assign bus.inst_addr    = pc_q;
  assign bus.IF_ID_ins    = ins_q;
  assign bus.IF_ID_inc_pc = inc_pc_q;
  assign bus.IF_ID_valid  = valid_q;
  assign bus.halted       = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_if_id.sv
// Directed bench for fetch_if_id: per-edge expectations are queued as stimulus
// is driven and compared once the edge has produced the DUT outputs.
`default_nettype none

module tb_fetch_if_id;

  localparam logic [15:0] NOP = 16'h0800;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] ins;
    logic [15:0] inc;
    logic        valid;
    logic        halted;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  fetch_if_id_if bus ();

  fetch_if_id #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory image: HALT at 000A, otherwise ADDI words (opcode 01000) tagged with the address.
  function automatic logic [15:0] word(input logic [15:0] a);
    if (a == 16'h000A) return 16'h0000;
    return {5'b01000, a[10:0]};
  endfunction

  assign bus.inst_data = word(bus.inst_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_now(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".addr"},   bus.inst_addr,            e.addr);
    check({tag, ".ins"},    bus.IF_ID_ins,            e.ins);
    check({tag, ".inc"},    bus.IF_ID_inc_pc,         e.inc);
    check({tag, ".valid"},  {15'd0, bus.IF_ID_valid}, {15'd0, e.valid});
    check({tag, ".halted"}, {15'd0, bus.halted},      {15'd0, e.halted});
  endtask

  // Drive one cycle of controls, queue the expected post-edge state, then compare.
  task automatic step(input string tag, input logic stall, input logic flush,
                      input logic [1:0] src, input logic [15:0] tgt,
                      input logic [15:0] e_addr, input logic [15:0] e_ins,
                      input logic [15:0] e_inc, input logic e_valid, input logic e_halted);
    exp_t e;
    bus.stall_decode = stall;
    bus.flush_fetch  = flush;
    bus.PC_source    = src;
    bus.target_pc    = tgt;
    e = '{addr: e_addr, ins: e_ins, inc: e_inc, valid: e_valid, halted: e_halted};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_now(tag);
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.stall_decode = 1'b0;
    bus.flush_fetch  = 1'b0;
    bus.PC_source    = 2'b00;
    bus.target_pc    = 16'h0000;

    #2;
    e = '{addr: 16'h0000, ins: NOP, inc: 16'h0000, valid: 1'b0, halted: 1'b0};
    sb_q.push_back(e);
    compare_now("reset");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch from 0000
    step("seq0", 0, 0, 2'b00, 16'h0, 16'h0002, word(16'h0000), 16'h0002, 1, 0);
    step("seq1", 0, 0, 2'b00, 16'h0, 16'h0004, word(16'h0002), 16'h0004, 1, 0);

    // Stall three cycles while inst_addr is 0004
    for (int i = 0; i < 3; i++)
      step("stall", 1, 0, 2'b00, 16'h0, 16'h0004, word(16'h0002), 16'h0004, 1, 0);
    step("unstall", 0, 0, 2'b00, 16'h0, 16'h0006, word(16'h0004), 16'h0006, 1, 0);
    step("seq2",    0, 0, 2'b00, 16'h0, 16'h0008, word(16'h0006), 16'h0008, 1, 0);

    // Redirect to 0040: one bubble then target instruction
    step("redir40", 0, 1, 2'b10, 16'h0040, 16'h0040, NOP, 16'h0000, 0, 0);
    step("tgt40",   0, 0, 2'b00, 16'h0000, 16'h0042, word(16'h0040), 16'h0042, 1, 0);

    // Redirect beats a simultaneous stall
    step("redir_stall", 1, 1, 2'b10, 16'h0100, 16'h0100, NOP, 16'h0000, 0, 0);
    step("tgt100",      0, 0, 2'b00, 16'h0000, 16'h0102, word(16'h0100), 16'h0102, 1, 0);

    // PC_source alone also redirects
    step("redir_src", 0, 0, 2'b10, 16'h0006, 16'h0006, NOP, 16'h0000, 0, 0);
    step("tgt6",      0, 0, 2'b00, 16'h0000, 16'h0008, word(16'h0006), 16'h0008, 1, 0);
    step("fetch8",    0, 0, 2'b01, 16'h0000, 16'h000A, word(16'h0008), 16'h000A, 1, 0);

    // HALT at 000A
    step("halt",       0, 0, 2'b00, 16'h0, 16'h000A, 16'h0000, 16'h000C, 1, 1);
    step("halt_stall", 1, 0, 2'b00, 16'h0, 16'h000A, 16'h0000, 16'h000C, 1, 1);
    for (int i = 0; i < 10; i++)
      step("halted_bub", 0, 0, 2'b00, 16'h0, 16'h000A, NOP, 16'h0000, 0, 1);
    step("halted_stall", 1, 0, 2'b00, 16'h0, 16'h000A, NOP, 16'h0000, 0, 1);

    // Redirect leaves HALTED
    step("redir20", 0, 1, 2'b10, 16'h0020, 16'h0020, NOP, 16'h0000, 0, 0);
    step("tgt20",   0, 0, 2'b00, 16'h0000, 16'h0022, word(16'h0020), 16'h0022, 1, 0);

    // PC wrap at FFFE
    step("redirFFFE", 0, 1, 2'b10, 16'hFFFE, 16'hFFFE, NOP, 16'h0000, 0, 0);
    step("wrap",      0, 0, 2'b00, 16'h0000, 16'h0000, word(16'hFFFE), 16'h0000, 1, 0);
    step("after_wrap",0, 0, 2'b00, 16'h0000, 16'h0002, word(16'h0000), 16'h0002, 1, 0);

    // Asynchronous reset mid-cycle while stalled
    @(negedge clk);
    bus.stall_decode = 1'b1;
    rst = 1'b1;
    #1;
    e = '{addr: 16'h0000, ins: NOP, inc: 16'h0000, valid: 1'b0, halted: 1'b0};
    sb_q.push_back(e);
    compare_now("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 0, 0, 2'b00, 16'h0, 16'h0002, word(16'h0000), 16'h0002, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
